// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, with retired-instruction count and sticky traps.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic             waiting;
  logic             retire;

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    waiting     = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        waiting = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        waiting = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        waiting = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase

    // A ready on the boundary cycle completes the access instead of trapping.
    if (waiting && !mem_ready && wait_q == WAIT_MAX) begin
      state_d     = S_TRAP;
      bus_error_d = 1'b1;
    end

    if (state_d != state_q)       wait_d = '0;
    else if (waiting && !mem_ready) wait_d = wait_q + 8'd1;
    else                          wait_d = wait_q;

    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_source = 2'b01;
          pc_write  = zero;
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_write  = 1'b1;
        end
        S_ADDIWB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign bus_error     = bus_error_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes the hand-derived
// per-cycle response, a negedge monitor pops and compares it.
module tb_mips_multicycle_ctrl;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [5:0]    opcode;
  logic          pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg;
  logic          reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [3:0]    state;
  logic          illegal, bus_error;
  logic [CW-1:0] instr_retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CW), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state), .illegal(illegal),
    .bus_error(bus_error), .instr_retired(instr_retired)
  );

  // Control word: {pc_write,ir_write,iord,mem_read,mem_write,mem_to_reg,reg_dst,
  //                reg_write,alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [14:0] C_ZERO    = {9'b000000000, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_FETCH_R = {9'b110100000, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] C_FETCH_W = {9'b000100000, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] C_DECODE  = {9'b000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMADR  = {9'b000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMRD   = {9'b001100000, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMWB   = {9'b000001010, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_MEMWR   = {9'b001010000, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_EXEC    = {9'b000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [14:0] C_ALUWB   = {9'b000000110, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] C_BR_Z    = {9'b100000001, 2'b00, 2'b01, 2'b01};
  localparam logic [14:0] C_BR_NZ   = {9'b000000001, 2'b00, 2'b01, 2'b01};
  localparam logic [14:0] C_JUMP    = {9'b100000000, 2'b00, 2'b00, 2'b10};
  localparam logic [14:0] C_ADDIWB  = {9'b000000010, 2'b00, 2'b00, 2'b00};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic [24:0] v;
    int          id;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            ncyc = 0;
  logic [CW-1:0] er = '0;
  logic          ie = 1'b0;
  logic          be = 1'b0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [24:0] act;
      e   = sb.pop_front();
      act = {state, pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             instr_retired, illegal, bus_error};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL cycle%0d {state,ctrl,retired,illegal,bus_error}: got %h want %h",
                 e.id, act, e.v);
      end
    end
  end

  task automatic cyc(input logic rst, input logic mr, input logic z, input logic [5:0] op,
                     input logic [3:0] st, input logic [14:0] c);
    exp_t e;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    e.v       = {st, c, er, ie, be};
    e.id      = ncyc;
    sb.push_back(e);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] st);
    cyc(1'b1, 1'b1, 1'b1, OP_R, st, C_ZERO);
    er = '0;
    ie = 1'b0;
    be = 1'b0;
  endtask

  task automatic do_j();
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd9, C_JUMP);
    er++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
    @(posedge clk);
    #1;
    do_reset(4'd0);

    // R-type: 0,1,6,7
    cyc(1'b0, 1'b1, 1'b0, OP_R, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_R, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_R, 4'd6, C_EXEC);
    cyc(1'b0, 1'b1, 1'b0, OP_R, 4'd7, C_ALUWB);
    er++;
    // lw with three not-ready cycles in MEMRD: 8 cycles
    cyc(1'b0, 1'b1, 1'b0, OP_LW, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_LW, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_LW, 4'd2, C_MEMADR);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, OP_LW, 4'd3, C_MEMRD);
    cyc(1'b0, 1'b1, 1'b0, OP_LW, 4'd3, C_MEMRD);
    cyc(1'b0, 1'b1, 1'b0, OP_LW, 4'd4, C_MEMWB);
    er++;
    // sw
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd2, C_MEMADR);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd5, C_MEMWR);
    er++;
    // addi
    cyc(1'b0, 1'b1, 1'b0, OP_ADDI, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_ADDI, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_ADDI, 4'd10, C_MEMADR);
    cyc(1'b0, 1'b1, 1'b0, OP_ADDI, 4'd11, C_ADDIWB);
    er++;
    // beq taken, then not taken
    cyc(1'b0, 1'b1, 1'b1, OP_BEQ, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b1, OP_BEQ, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b1, OP_BEQ, 4'd8, C_BR_Z);
    er++;
    cyc(1'b0, 1'b1, 1'b0, OP_BEQ, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_BEQ, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_BEQ, 4'd8, C_BR_NZ);
    er++;
    do_j();

    // Reset during MEMWR: strobe drops in the reset cycle, nothing retires
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, 4'd2, C_MEMADR);
    cyc(1'b0, 1'b0, 1'b0, OP_SW, 4'd5, C_MEMWR);
    do_reset(4'd5);

    // Counter wrap: 16 jumps with a 4-bit counter return to 0
    for (int i = 0; i < 16; i++) do_j();

    // Illegal opcode: trap held 20 cycles, counter unchanged
    cyc(1'b0, 1'b1, 1'b0, OP_BAD, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_BAD, 4'd1, C_DECODE);
    ie = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2), 1'b1, OP_R, 4'd12, C_ZERO);
    do_reset(4'd12);

    // Fetch timeout: 16 not-ready cycles in FETCH, then trap
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, OP_J, 4'd0, C_FETCH_W);
    be = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd12, C_ZERO);
    do_reset(4'd12);

    // Ready on the boundary cycle completes the fetch
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, OP_J, 4'd0, C_FETCH_W);
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd0, C_FETCH_R);
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd1, C_DECODE);
    cyc(1'b0, 1'b1, 1'b0, OP_J, 4'd9, C_JUMP);
    er++;
    cyc(1'b0, 1'b0, 1'b0, OP_J, 4'd0, C_FETCH_W);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control sequencer for the MIPS datapath: replaces the single-cycle opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC write enable, the IR load, the shared instruction/data memory port (with a ready handshake), and the register-file and ALU mux selects. It also maintains a retired-instruction counter and traps on illegal opcodes or memory timeouts.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- TIMEOUT, 15, maximum wait cycles for mem_ready in a memory state before a bus-error trap (1..255)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- opcode  in  6  instruction[31:26] from the IR
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load IR from memory read data
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- mem_to_reg  out  1  writeback data select: 1 = memory data register
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state (debug)
- illegal, bus_error  out  1 each  sticky trap causes
- instr_retired  out  CNT_W  count of completed instructions

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode traps.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12.
- Outputs are a combinational decode of state, plus mem_ready and zero where noted. Any output not listed for a state is 0.
- **FETCH:** mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay, with ir_write=0 and pc_write=0.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - any other opcode → TRAP with illegal set
- **MEMADR:** alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD:** mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
- **MEMWB:** reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- **MEMWR:** mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
- **EXEC:** alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- **ALUWB:** reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero. Go to FETCH.
- **JUMP:** pc_source=10, pc_write=1. Go to FETCH.
- **ADDIEX:** same selects as MEMADR. Go to ADDIWB.
- **ADDIWB:** reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- **TRAP:** all strobes 0. Held until reset.
- **Wait counter** (8-bit):
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR while mem_ready=0.
  - When the counter equals TIMEOUT and mem_ready=0: go to TRAP, set bus_error.
  - mem_ready=1 on that same cycle wins: the access completes and no trap occurs.
- **instr_retired:** increments by 1 on the final cycle of each instruction, namely:
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP
  - MEMWR when mem_ready=1
  - Wraps modulo 2^CNT_W. No increment in TRAP and no increment for a trapped instruction.

## Timing
- **Reset asserted at a clock edge:**
  - state becomes FETCH.
  - wait counter, instr_retired, illegal and bus_error become 0.
  - While reset is high, all control outputs are forced to 0.
- Reset mid-instruction (including mid-access or in TRAP) abandons the instruction with no further strobes. Fetch restarts on the first cycle after reset deasserts.
- **Latency with mem_ready held at 1:**
  - beq and j: 3 cycles
  - R-type, sw and addi: 4 cycles
  - lw: 5 cycles
- Each cycle of mem_ready=0 in a wait state adds exactly one cycle.
- The memory handshake completes in the same cycle mem_ready is sampled high. The strobe is held continuously until then and drops on the next cycle.
- pc_write and ir_write pulse exactly once per fetch.

## Test plan
- **R-type add,** mem_ready=1: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_retired goes 0→1.
- **lw with mem_ready low for 3 cycles in MEMRD:** 8 cycles total; mem_read held high for 4 cycles with iord=1; then MEMWB with mem_to_reg=1.
- **beq:**
  - with zero=1: pc_write=1 and pc_source=01 in state 8.
  - with zero=0: pc_write=0.
  - Both cases retire in 3 cycles.
- **Illegal opcode 111111:** DECODE→TRAP; illegal=1; state stays 12 for 20 cycles; instr_retired unchanged; reset clears illegal and returns to FETCH.
- **Timeout, TIMEOUT=15:** mem_ready held 0 in FETCH traps with bus_error=1. In a separate run, mem_ready=1 on the boundary cycle completes the fetch with no trap.
- **Counter wrap, CNT_W=4:** 16 j instructions take instr_retired back to 0. Reset asserted during MEMWR: mem_write drops immediately and no write completes.
